control_unit: RTL

Hardwired control sequencer that drives every datapath strobe of `System` from the instruction in IR. It replaces per-instruction stimulus with a Moore FSM covering fetch and these instructions: `mfhi`, `mflo`, `addi`, `andi`, `ori`, `ld`, `st`, `nop` and `halt`. It sits directly upstream of `System`, and its outputs connect one-to-one to `System`'s control ports.

---
 rtl/cpu_pkg.sv | 75 +++++++
 rtl/ctrl_decode.sv | 107 ++++++++++
 rtl/control_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU ops, state codes and control word layout
package cpu_pkg;

    // Instruction opcodes, IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_ANDI = 5'b01011;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Datapath ALU operation selects
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    // Sequencer states; ALU4 and MA5 are split per instruction class so the
    // control word stays a pure function of the state register after T3.
    typedef logic [4:0] state_t;
    localparam state_t S_RST     = 5'd0;
    localparam state_t S_T0      = 5'd1;
    localparam state_t S_T1      = 5'd2;
    localparam state_t S_T2      = 5'd3;
    localparam state_t S_T3      = 5'd4;
    localparam state_t S_ALU_ADD = 5'd5;
    localparam state_t S_ALU_AND = 5'd6;
    localparam state_t S_ALU_OR  = 5'd7;
    localparam state_t S_ALU_LD  = 5'd8;
    localparam state_t S_ALU_ST  = 5'd9;
    localparam state_t S_IMM5    = 5'd10;
    localparam state_t S_MA5_LD  = 5'd11;
    localparam state_t S_MA5_ST  = 5'd12;
    localparam state_t S_LD6     = 5'd13;
    localparam state_t S_LD7     = 5'd14;
    localparam state_t S_ST6     = 5'd15;
    localparam state_t S_ST7     = 5'd16;
    localparam state_t S_HALT    = 5'd17;

    // Full control word, one field per System control port
    typedef struct packed {
        logic       pc_out;
        logic       mdr_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       hi_out;
        logic       lo_out;
        logic       inport_out;
        logic       c_out;
        logic       ba_out;
        logic       r_out;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       r_in;
        logic       outport_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       inc_pc;
        logic       mem_read;
        logic       mem_write;
        logic       mem_enable;
        logic [4:0] opcode;
        logic       run;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - state to control word decode
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] ir_op,
    output ctrl_t      ctrl
);

    // Decode the control word; only T3 looks at the (already registered) IR opcode
    always_comb begin
        ctrl        = '0;
        ctrl.opcode = ALU_ADD;
        ctrl.run    = 1'b1;
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl.zlo_out    = 1'b1;
                ctrl.pc_in      = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_enable = 1'b1;
                ctrl.mdr_in     = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                case (ir_op)
                    OP_MFHI: begin
                        ctrl.gra    = 1'b1;
                        ctrl.hi_out = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    OP_MFLO: begin
                        ctrl.gra    = 1'b1;
                        ctrl.lo_out = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_ALU_ADD, S_ALU_LD, S_ALU_ST: begin
                ctrl.c_out = 1'b1;
                ctrl.z_in  = 1'b1;
            end
            S_ALU_AND: begin
                ctrl.c_out  = 1'b1;
                ctrl.z_in   = 1'b1;
                ctrl.opcode = ALU_AND;
            end
            S_ALU_OR: begin
                ctrl.c_out  = 1'b1;
                ctrl.z_in   = 1'b1;
                ctrl.opcode = ALU_OR;
            end
            S_IMM5: begin
                ctrl.zlo_out = 1'b1;
                ctrl.gra     = 1'b1;
                ctrl.r_in    = 1'b1;
            end
            S_MA5_LD, S_MA5_ST: begin
                ctrl.zlo_out = 1'b1;
                ctrl.mar_in  = 1'b1;
            end
            S_LD6: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_enable = 1'b1;
                ctrl.mdr_in     = 1'b1;
            end
            S_LD7: begin
                ctrl.mdr_out = 1'b1;
                ctrl.gra     = 1'b1;
                ctrl.r_in    = 1'b1;
            end
            S_ST6: begin
                ctrl.gra    = 1'b1;
                ctrl.r_out  = 1'b1;
                ctrl.mdr_in = 1'b1;
            end
            S_ST7: begin
                ctrl.mem_write  = 1'b1;
                ctrl.mem_enable = 1'b1;
            end
            default: begin
                ctrl.opcode = '0;
                ctrl.run    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute sequencer for System
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  Stop,
    output logic                  PCout,
    output logic                  MDRout,
    output logic                  Zhi_out,
    output logic                  Zlo_out,
    output logic                  HIout,
    output logic                  LOout,
    output logic                  Inport_out,
    output logic                  Cout,
    output logic                  BAout,
    output logic                  Rout,
    output logic                  PCin,
    output logic                  MARin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Zin,
    output logic                  HIin,
    output logic                  LOin,
    output logic                  Rin,
    output logic                  outport_in,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  Grc,
    output logic                  IncPC,
    output logic                  Mem_Read,
    output logic                  Mem_Write,
    output logic                  Mem_enable512x32,
    output logic [4:0]            opcode,
    output logic                  Run
);

    state_t     state;
    state_t     state_next;
    state_t     retire;
    logic       stop_pending;
    logic [4:0] ir_op;
    logic       unused_ir;
    ctrl_t      ctrl;

    assign ir_op     = IR[DATA_WIDTH-1 -: 5];
    assign unused_ir = ^IR[DATA_WIDTH-6:0];

    // Where a finished instruction goes: a Stop seen now or earlier turns the fetch into HALT
    assign retire = (stop_pending || Stop) ? S_HALT : S_T0;

    // Next-state selection
    always_comb begin
        state_next = S_RST;
        case (state)
            S_RST:     state_next = S_T0;
            S_T0:      state_next = S_T1;
            S_T1:      state_next = S_T2;
            S_T2:      state_next = S_T3;
            S_T3: begin
                case (ir_op)
                    OP_MFHI, OP_MFLO, OP_NOP: state_next = retire;
                    OP_ADDI: state_next = S_ALU_ADD;
                    OP_ANDI: state_next = S_ALU_AND;
                    OP_ORI:  state_next = S_ALU_OR;
                    OP_LD:   state_next = S_ALU_LD;
                    OP_ST:   state_next = S_ALU_ST;
                    default: state_next = S_HALT;
                endcase
            end
            S_ALU_ADD, S_ALU_AND, S_ALU_OR: state_next = S_IMM5;
            S_ALU_LD:  state_next = S_MA5_LD;
            S_ALU_ST:  state_next = S_MA5_ST;
            S_MA5_LD:  state_next = S_LD6;
            S_LD6:     state_next = S_LD7;
            S_MA5_ST:  state_next = S_ST6;
            S_ST6:     state_next = S_ST7;
            S_IMM5, S_LD7, S_ST7: state_next = retire;
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_RST;
        endcase
    end

    // State register and sticky stop request; clear wins over everything
    always_ff @(posedge Clock) begin
        if (clear) begin
            state        <= S_RST;
            stop_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (Stop) begin
                stop_pending <= 1'b1;
            end
        end
    end

    ctrl_decode u_ctrl_decode (
        .state (state),
        .ir_op (ir_op),
        .ctrl  (ctrl)
    );

    assign PCout            = ctrl.pc_out;
    assign MDRout           = ctrl.mdr_out;
    assign Zhi_out          = ctrl.zhi_out;
    assign Zlo_out          = ctrl.zlo_out;
    assign HIout            = ctrl.hi_out;
    assign LOout            = ctrl.lo_out;
    assign Inport_out       = ctrl.inport_out;
    assign Cout             = ctrl.c_out;
    assign BAout            = ctrl.ba_out;
    assign Rout             = ctrl.r_out;
    assign PCin             = ctrl.pc_in;
    assign MARin            = ctrl.mar_in;
    assign MDRin            = ctrl.mdr_in;
    assign IRin             = ctrl.ir_in;
    assign Yin              = ctrl.y_in;
    assign Zin              = ctrl.z_in;
    assign HIin             = ctrl.hi_in;
    assign LOin             = ctrl.lo_in;
    assign Rin              = ctrl.r_in;
    assign outport_in       = ctrl.outport_in;
    assign Gra              = ctrl.gra;
    assign Grb              = ctrl.grb;
    assign Grc              = ctrl.grc;
    assign IncPC            = ctrl.inc_pc;
    assign Mem_Read         = ctrl.mem_read;
    assign Mem_Write        = ctrl.mem_write;
    assign Mem_enable512x32 = ctrl.mem_enable;
    assign opcode           = ctrl.opcode;
    assign Run              = ctrl.run;

endmodule
